// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencing for the 5-stage pipeline (load-use, divider,
// branch/jump squash, fetch wait, post-reset warm-up) plus a saturating stall counter.
module pipe_hazard_ctrl #(
   parameter int DIV_LAT  = 16,
   parameter int INIT_CYC = 2,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_jump,
   input  logic             id_div_start,
   input  logic             id_uses_hilo,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             imem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             div_busy,
   output logic [CNT_W-1:0] stall_count
);
   typedef enum logic {INIT, RUN} state_t;
   state_t     state;
   logic [3:0] init_cnt;
   logic [7:0] div_cnt;
   logic       run, load_use, div_stall, advance;
   logic [4:0] ctl;
   assign run       = state == RUN && !reset;
   assign load_use  = ex_mem_read && ex_rd != 5'd0 &&
                      ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
   assign div_busy  = div_cnt != 8'd0;
   assign div_stall = div_busy && (id_uses_hilo || id_div_start);
   // ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush}, first matching rule wins
   assign ctl = !run                     ? 5'b00101 :
                ex_branch_taken          ? 5'b11111 :
                (load_use || div_stall)  ? 5'b00011 :
                id_jump                  ? 5'b11110 :
                !imem_ready              ? 5'b01110 :
                                           5'b11010;
   assign {pc_en, ifid_en, ifid_flush, idex_en, idex_flush} = ctl;
   assign advance = run && !ex_branch_taken && !load_use && !div_stall;
   always_ff @(posedge clk)
      if (reset) begin
         state       <= INIT;
         init_cnt    <= 4'(INIT_CYC - 1);
         div_cnt     <= '0;
         stall_count <= '0;
      end else begin
         if (state == INIT) begin
            if (init_cnt == 4'd0) state <= RUN;
            else init_cnt <= init_cnt - 4'd1;
         end
         div_cnt <= (advance && id_div_start) ? 8'(DIV_LAT) : div_busy ? div_cnt - 8'd1 : div_cnt;
         if (run && !pc_en && stall_count != '1) stall_count <= stall_count + 1'b1;
      end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random stimulus; a time-based reference model pushes
// expected outputs into a queue which a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
   localparam int DIV_LAT  = 4;
   localparam int INIT_CYC = 2;
   localparam int CNT_W    = 4;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset;
   logic [4:0] id_rs, id_rt, ex_rd;
   logic id_uses_rs, id_uses_rt, id_jump, id_div_start, id_uses_hilo;
   logic ex_mem_read, ex_branch_taken, imem_ready;
   logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, div_busy;
   logic [CNT_W-1:0] stall_count;

   pipe_hazard_ctrl #(.DIV_LAT(DIV_LAT), .INIT_CYC(INIT_CYC), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
      .id_div_start(id_div_start), .id_uses_hilo(id_uses_hilo), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
      .idex_flush(idex_flush), .div_busy(div_busy), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]       ctl;
      logic             busy;
      logic [CNT_W-1:0] cnt;
   } exp_t;
   exp_t q[$];
   int checks = 0;
   int errors = 0;

   // model state: time since reset release, cycle of the last accepted divide, stall total
   int tnow      = 0;
   int since_rel = 0;
   int last_div  = -1000;
   int scount    = 0;

   task automatic idle();
      id_rs = 0; id_rt = 0; ex_rd = 0;
      id_uses_rs = 0; id_uses_rt = 0; id_jump = 0; id_div_start = 0; id_uses_hilo = 0;
      ex_mem_read = 0; ex_branch_taken = 0; imem_ready = 1;
   endtask

   task automatic tick();
      exp_t e;
      bit run, busy, lu, ds;
      bit p, fe, ff, de, df;
      busy = (tnow - last_div) >= 1 && (tnow - last_div) <= DIV_LAT;
      run  = !reset && since_rel >= INIT_CYC;
      lu   = ex_mem_read && ex_rd != 0 &&
             ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
      ds   = busy && (id_uses_hilo || id_div_start);
      if (!run) begin
         p = 0; fe = 0; ff = 1; de = 0; df = 1;
      end else if (ex_branch_taken) begin
         p = 1; fe = 1; ff = 1; de = 1; df = 1;
      end else if (lu || ds) begin
         p = 0; fe = 0; ff = 0; de = 1; df = 1;
      end else if (id_jump) begin
         p = 1; fe = 1; ff = 1; de = 1; df = 0;
      end else if (!imem_ready) begin
         p = 0; fe = 1; ff = 1; de = 1; df = 0;
      end else begin
         p = 1; fe = 1; ff = 0; de = 1; df = 0;
      end
      e.ctl  = {p, fe, ff, de, df};
      e.busy = busy;
      e.cnt  = CNT_W'(scount);
      q.push_back(e);
      if (reset) begin
         since_rel = 0; last_div = -1000; scount = 0;
      end else begin
         since_rel++;
         if (run && !p && scount < CNT_MAX) scount++;
         if (run && id_div_start && !ex_branch_taken && !lu && !ds) last_div = tnow;
      end
      tnow++;
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin : monitor
      exp_t e;
      logic [4:0] act;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e   = q.pop_front();
            act = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush};
            checks += 3;
            if (act !== e.ctl) begin
               errors++;
               $display("FAIL ctl t=%0t got %b want %b", $time, act, e.ctl);
            end
            if (div_busy !== e.busy) begin
               errors++;
               $display("FAIL div_busy t=%0t got %b want %b", $time, div_busy, e.busy);
            end
            if (stall_count !== e.cnt) begin
               errors++;
               $display("FAIL stall_count t=%0t got %0d want %0d", $time, stall_count, e.cnt);
            end
         end
      end
   end

   initial begin : driver
      idle();
      reset = 1;
      @(posedge clk);
      #1;
      ticks(2);
      reset = 0;
      ticks(4);
      // load-use on r5, then same pattern on r0 must not stall
      ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1; tick();
      idle(); tick();
      ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1; tick();
      idle(); tick();
      ex_mem_read = 1; ex_rd = 7; id_rt = 7; id_uses_rt = 1; tick();
      ex_branch_taken = 1; tick();
      idle(); tick();
      // divide then mfhi two cycles later, held until it advances
      id_div_start = 1; tick();
      idle(); tick();
      id_uses_hilo = 1; ticks(4);
      idle(); tick();
      id_jump = 1; tick();
      idle(); imem_ready = 0; ticks(3);
      idle(); tick();
      imem_ready = 0; ticks(20);
      idle(); ticks(2);
      // reset mid-divide
      id_div_start = 1; tick();
      idle(); tick();
      reset = 1; tick();
      reset = 0; ticks(4);
      for (int i = 0; i < 3000; i++) begin
         reset           = ($urandom_range(0, 299) == 0);
         id_rs           = 5'($urandom_range(0, 3));
         id_rt           = 5'($urandom_range(0, 3));
         ex_rd           = 5'($urandom_range(0, 3));
         id_uses_rs      = 1'($urandom_range(0, 1));
         id_uses_rt      = 1'($urandom_range(0, 1));
         ex_mem_read     = ($urandom_range(0, 3) == 0);
         ex_branch_taken = ($urandom_range(0, 7) == 0);
         id_jump         = ($urandom_range(0, 7) == 0);
         id_div_start    = ($urandom_range(0, 9) == 0);
         id_uses_hilo    = ($urandom_range(0, 5) == 0);
         imem_ready      = ($urandom_range(0, 4) != 0);
         tick();
      end
      idle(); reset = 0; ticks(2);
      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
